seq_chunk_adder: RTL
====================

Name: seq_chunk_adder

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, holding the carry in a register between chunks.
- Trades latency for a short carry chain and uses valid/ready handshakes on input and output.
- Sits in datapaths where a full-width ripple chain would miss timing.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be ≥ 1.
- CHUNK, 4: bits processed per cycle. WIDTH % CHUNK must be 0; elaboration fails otherwise.
- NCHUNK: derived, WIDTH/CHUNK. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (carry-in for add, set to 1 for a plain subtract)
- sub  input  1  0: a+b+cin; 1: a+~b+cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry out of the MSB (for subtract, 0 = borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0; chunk counter and carry register =0.
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures a, b (inverted if sub), cin, and the MSBs of a and b_eff, then goes to RUN with k=0.
  - RUN: in_ready=0. Each cycle adds chunk k of a and b_eff plus the carry register, writes s[k*CHUNK +: CHUNK], updates the carry register, and increments k. After chunk NCHUNK-1 it goes to DONE.
  - DONE: out_valid=1. s, cout and ovf are stable and held until out_ready=1.
- Leaving DONE:
  - On out_ready with in_valid=0: go to IDLE.
  - in_ready = IDLE | (DONE & out_ready), so a new transfer can be accepted in the same cycle the result is consumed; the next state is then RUN with k=0.
- Latency and throughput:
  - Accept at edge N → out_valid=1 after edge N+NCHUNK.
  - CHUNK=WIDTH gives 1-cycle latency.
  - Back-to-back throughput: one result per NCHUNK+1 cycles.
- Operand capture: a, b, cin and sub are sampled only at the accept edge. Changes afterwards have no effect.
- Flags (set on the final chunk):
  - cout = final carry.
  - ovf = (a_msb == b_eff_msb) & (s_msb != a_msb).
- s update: s is written chunk-by-chunk during RUN; its intermediate value is don't-care to consumers. s, cout and ovf keep their last value in IDLE.
- Input handshake: in_valid while in_ready=0 is ignored, with no side effect. The producer must hold its request until accepted.
- Reset mid-operation: rst_n low in any state immediately forces the reset values. The in-flight operation is discarded and no out_valid is produced for it.
- Wrap-around: results are modulo 2^WIDTH; the overflowed bit appears only on cout.

Test Plan (WIDTH=16, CHUNK=4):
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0 → s=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 during RUN.
- Carry propagation across all chunks: a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
- Subtract: sub=1, cin=1.
  - a=0x0005, b=0x0007 → s=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 → s=0x7FFF, cout=1, ovf=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE → s, cout and ovf are unchanged and out_valid stays 1.
  - Then raise out_ready with in_valid=1 (a=0x0001, b=0x0002) → accepted the same cycle; the next result is s=0x0003.
- Reset and ignored inputs:
  - Drop rst_n at RUN k=2 → outputs return to reset values asynchronously; no out_valid for the aborted operation; the next transaction is correct.
  - in_valid pulsed during RUN → ignored.
- Parameter sweep: CHUNK=16 → latency 1; CHUNK=1 → latency 16. Random a, b, cin and sub each match the reference sum, carry and overflow.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered carry between chunks,
// valid/ready on both sides, result held in DONE until the consumer takes it.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_chunk_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be >= 1 and an exact multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             carry_q, a_msb_q, b_msb_q, cout_q, ovf_q;

    logic             in_ready, out_valid, accept, last_chunk;
    logic [WIDTH-1:0] b_eff, s_nxt;
    logic [CHUNK:0]   chunk_sum;

    // Operands shift right one chunk per cycle so the active chunk is always at bit 0;
    // result chunks enter from the top and end up in place after NCHUNK shifts.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        b_eff      = bus.sub ? ~bus.b : bus.b;
        last_chunk = (k_q == KW'(NCHUNK - 1));
        chunk_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        s_nxt      = (s_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

        unique case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  if (last_chunk) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    in_ready = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accepting overrides the DONE->IDLE move so back-to-back transfers lose no cycle.
        accept = in_ready & bus.in_valid;
        if (accept) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath is small, so every register including operands is reset; no memories here.
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= b_eff;
                carry_q <= bus.cin;
                a_msb_q <= bus.a[WIDTH-1];
                b_msb_q <= b_eff[WIDTH-1];
                k_q     <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                s_q     <= s_nxt;
                carry_q <= chunk_sum[CHUNK];
                k_q     <= k_q + 1'b1;
                if (last_chunk) begin
                    cout_q <= chunk_sum[CHUNK];
                    ovf_q  <= (a_msb_q == b_msb_q) & (chunk_sum[CHUNK-1] != a_msb_q);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
